// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the fetch FSM state encoding.
package rv32i_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_INC           = 4;

    typedef enum logic {
        ISSUE = 1'b0,
        WAIT  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if_out_reg.sv
// One-entry valid/ready holding register for a fetched instruction and its PC.
module if_out_reg
    import rv32i_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              flush,
    input  logic              load,
    input  logic [DATA_W-1:0] load_instr,
    input  logic [PC_W-1:0]   load_pc,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc
);

    logic              valid_reg, valid_next;
    logic [DATA_W-1:0] instr_reg;
    logic [PC_W-1:0]   pc_reg;

    // Flush wins over load; a transfer with no new load empties the slot.
    always_comb begin
        valid_next = valid_reg;
        if (flush)
            valid_next = 1'b0;
        else if (load)
            valid_next = 1'b1;
        else if (out_ready)
            valid_next = 1'b0;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            valid_reg <= 1'b0;
            instr_reg <= DATA_W'(NOP_INSTR);
            pc_reg    <= '0;
        end else begin
            valid_reg <= valid_next;
            if (load && !flush) begin
                instr_reg <= load_instr;
                pc_reg    <= load_pc;
            end
        end
    end

    assign out_valid = valid_reg;
    assign out_instr = instr_reg;
    assign out_pc    = pc_reg;

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction fetch: PC owner, addr/ready memory initiator, one-word prefetch.
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter int          PC_W       = 32,
    parameter int          MEM_ADDR_W = 8,
    parameter int          DATA_W     = 32,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,
    input  logic                  fetch_en,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_W-1:0]     if_instr,
    output logic [PC_W-1:0]       if_pc,
    input  logic                  redirect_valid,
    input  logic [PC_W-1:0]       redirect_pc,
    output logic                  fetch_err
);

    localparam logic [PC_W-1:0] RESET_PC_L = PC_W'(RESET_PC);

    fetch_state_t          state_reg, state_next;
    logic [PC_W-1:0]       pc_reg, pc_next;
    logic [MEM_ADDR_W-1:0] mem_addr_reg;
    logic                  fetch_err_reg;
    logic                  slot_free;
    logic                  capture;

    assign slot_free = !if_valid || if_ready;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n)
            state_reg <= ISSUE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (redirect_valid) begin
            state_next = ISSUE;
        end else begin
            case (state_reg)
                ISSUE:   if (fetch_en) state_next = WAIT;
                WAIT:    if (mem_ready && slot_free) state_next = ISSUE;
                default: state_next = ISSUE;
            endcase
        end
    end

    // mem_ready is only meaningful once the address has been held for a full cycle.
    always_comb begin
        capture = (state_reg == WAIT) && mem_ready && slot_free && !redirect_valid;
        pc_next = pc_reg;
        if (redirect_valid)
            pc_next = {redirect_pc[PC_W-1:2], 2'b00};
        else if (capture)
            pc_next = pc_reg + PC_W'(PC_INC);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pc_reg        <= RESET_PC_L;
            mem_addr_reg  <= RESET_PC_L[MEM_ADDR_W+1:2];
            fetch_err_reg <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            mem_addr_reg  <= pc_next[MEM_ADDR_W+1:2];
            fetch_err_reg <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign fetch_err = fetch_err_reg;

    if_out_reg #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) u_out_reg (
        .iCLK       (iCLK),
        .iRST_n     (iRST_n),
        .flush      (redirect_valid),
        .load       (capture),
        .load_instr (mem_data),
        .load_pc    (pc_reg),
        .out_ready  (if_ready),
        .out_valid  (if_valid),
        .out_instr  (if_instr),
        .out_pc     (if_pc)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a ROM whose ready rises two cycles after a request.
module tb_instr_fetch;

    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic        fetch_en = 1'b1;
    logic [7:0]  mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_data;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_err;

    logic        rst2_n = 1'b0;
    logic        fetch_en2 = 1'b1;
    logic        mem_ready2 = 1'b1;
    logic [7:0]  mem_addr2;
    logic [31:0] mem_data2;
    logic        if_valid2;
    logic        if_ready2 = 1'b1;
    logic [31:0] if_instr2;
    logic [31:0] if_pc2;
    logic        redirect_valid2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic        fetch_err2;

    logic [31:0] rom [256];
    int          errors = 0;
    int          checks = 0;
    int          age = 1;
    logic [7:0]  seen_addr = 8'h0;

    always #5 iCLK = ~iCLK;

    assign mem_data  = rom[mem_addr];
    assign mem_data2 = rom[mem_addr2];

    instr_fetch dut (
        .iCLK           (iCLK),
        .iRST_n         (iRST_n),
        .fetch_en       (fetch_en),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_data       (mem_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .iCLK           (iCLK),
        .iRST_n         (rst2_n),
        .fetch_en       (fetch_en2),
        .mem_addr       (mem_addr2),
        .mem_ready      (mem_ready2),
        .mem_data       (mem_data2),
        .if_valid       (if_valid2),
        .if_ready       (if_ready2),
        .if_instr       (if_instr2),
        .if_pc          (if_pc2),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2),
        .fetch_err      (fetch_err2)
    );

    // Request age restarts on reset, idle fetch or a new address; ready from the 3rd sample.
    always @(negedge iCLK) begin
        if (!iRST_n || !fetch_en || mem_addr != seen_addr)
            age = 1;
        else
            age = age + 1;
        seen_addr = mem_addr;
        mem_ready = (age >= 3);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge iCLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 | i;
        rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
        rom[8'h10] = 32'h55; rom[8'h11] = 32'h66;

        step(2);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_instr", if_instr, 32'h13);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_addr", {24'h0, mem_addr}, 32'h0);
        chk("rst_err", {31'h0, fetch_err}, 32'h0);

        // Streaming with decode always ready
        iRST_n = 1'b1;
        step(2);
        chk("s_novalid_e2", {31'h0, if_valid}, 32'h0);
        step(1);
        chk("s0_valid", {31'h0, if_valid}, 32'h1);
        chk("s0_instr", if_instr, 32'h11);
        chk("s0_pc", if_pc, 32'h0);
        chk("s0_addr", {24'h0, mem_addr}, 32'h1);
        step(1);
        chk("s0_taken", {31'h0, if_valid}, 32'h0);
        step(2);
        chk("s1_instr", if_instr, 32'h22);
        chk("s1_pc", if_pc, 32'h4);
        chk("s1_addr", {24'h0, mem_addr}, 32'h2);
        step(1);
        chk("s1_taken", {31'h0, if_valid}, 32'h0);
        step(1);
        chk("wait_a2", {24'h0, mem_addr}, 32'h2);

        // Redirect to 0x40 in the cycle the stale word 0x33 would be captured
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step(1);
        redirect_valid = 1'b0;
        chk("rd_valid", {31'h0, if_valid}, 32'h0);
        chk("rd_addr", {24'h0, mem_addr}, 32'h10);
        chk("rd_err", {31'h0, fetch_err}, 32'h0);
        step(2);
        chk("rd_nostale", {31'h0, if_valid}, 32'h0);
        step(1);
        chk("rd_instr", if_instr, 32'h55);
        chk("rd_pc", if_pc, 32'h40);
        chk("rd_addr1", {24'h0, mem_addr}, 32'h11);

        // Misaligned redirect target
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step(1);
        redirect_valid = 1'b0;
        chk("mis_err", {31'h0, fetch_err}, 32'h1);
        chk("mis_valid", {31'h0, if_valid}, 32'h0);
        chk("mis_addr", {24'h0, mem_addr}, 32'h10);
        step(1);
        chk("mis_err_off", {31'h0, fetch_err}, 32'h0);
        step(2);
        chk("mis_valid1", {31'h0, if_valid}, 32'h1);
        chk("mis_pc", if_pc, 32'h40);
        chk("mis_instr", if_instr, 32'h55);

        // Asynchronous reset in WAIT while a word is held
        if_ready = 1'b0;
        step(1);
        chk("ar_held", {31'h0, if_valid}, 32'h1);
        iRST_n = 1'b0;
        #1;
        chk("ar_valid", {31'h0, if_valid}, 32'h0);
        chk("ar_instr", if_instr, 32'h13);
        chk("ar_pc", if_pc, 32'h0);
        chk("ar_addr", {24'h0, mem_addr}, 32'h0);
        step(1);
        iRST_n = 1'b1;

        // Decode stall: slot holds 0x11 while the prefetch of 0x22 waits
        step(3);
        chk("st_instr0", if_instr, 32'h11);
        chk("st_pc0", if_pc, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk($sformatf("st_hold_instr%0d", i), if_instr, 32'h11);
            chk($sformatf("st_hold_addr%0d", i), {24'h0, mem_addr}, 32'h1);
        end
        if_ready = 1'b1;
        step(1);
        chk("st_b2b_valid", {31'h0, if_valid}, 32'h1);
        chk("st_b2b_instr", if_instr, 32'h22);
        chk("st_b2b_pc", if_pc, 32'h4);
        chk("st_b2b_addr", {24'h0, mem_addr}, 32'h2);
        step(3);
        chk("st_w2_instr", if_instr, 32'h33);
        chk("st_w2_pc", if_pc, 32'h8);
        chk("st_w2_addr", {24'h0, mem_addr}, 32'h3);

        // fetch_en held low after reset
        fetch_en = 1'b0;
        iRST_n = 1'b0;
        step(1);
        iRST_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk($sformatf("fe_idle%0d", i), {31'h0, if_valid}, 32'h0);
        end
        chk("fe_addr", {24'h0, mem_addr}, 32'h0);
        fetch_en = 1'b1;
        step(2);
        chk("fe_e2", {31'h0, if_valid}, 32'h0);
        step(1);
        chk("fe_e3_valid", {31'h0, if_valid}, 32'h1);
        chk("fe_e3_instr", if_instr, 32'h11);

        // PC wrap from the top word of the address space
        rst2_n = 1'b1;
        step(2);
        chk("wr_valid", {31'h0, if_valid2}, 32'h1);
        chk("wr_pc_top", if_pc2, 32'hFFFF_FFFC);
        chk("wr_instr_top", if_instr2, 32'hA000_00FF);
        step(2);
        chk("wr_pc_zero", if_pc2, 32'h0);
        chk("wr_instr_zero", if_instr2, 32'h11);
        chk("wr_addr", {24'h0, mem_addr2}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
